// File: rtl/mips_hazard_pkg.sv
// Shared types and constants for the MIPS 5-stage hazard controller.
// Shadow entries store register numbers at REG_AW_MAX bits so one struct serves any REG_AW up to that width.
package mips_hazard_pkg;

   localparam int unsigned REG_AW_DEF = 5;
   localparam int unsigned REG_AW_MAX = 8;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   typedef logic [REG_AW_MAX-1:0] reg_t;

   typedef struct packed {
      logic v;
      reg_t dst;
      logic rw;
      logic mr;
      reg_t rs;
      reg_t rt;
   } ex_entry_t;

   typedef struct packed {
      logic v;
      reg_t dst;
      logic rw;
   } pipe_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one in-flight producer against one register number.
module hazard_match
   import mips_hazard_pkg::*;
#(
   parameter int unsigned ZERO_HARD = 1
) (
   input  logic v,
   input  logic rw,
   input  reg_t dst,
   input  reg_t r,
   output logic match
);

   assign match = v && rw && (dst == r) && ((ZERO_HARD == 0) || (r != '0));

endmodule

// File: rtl/mips_hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: shadow scoreboard of EX/MEM/WB
// destinations, EX operand forwarding selects, load-use/interlock stall and branch flush.
module mips_hazard_unit
   import mips_hazard_pkg::*;
#(
   parameter int unsigned REG_AW    = REG_AW_DEF,
   parameter int unsigned FWD_EN    = 1,
   parameter int unsigned ZERO_HARD = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              mem_branch_taken,
   output logic              stall,
   output logic              bubble,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              flush_ex_mem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_count
);

   ex_entry_t   ex_q;
   pipe_entry_t mem_q;
   pipe_entry_t wb_q;

   reg_t rs_w;
   reg_t rt_w;
   reg_t dst_w;

   logic haz_rs;
   logic haz_rt;
   logic raw_stall;

   always_comb begin
      rs_w  = '0;
      rt_w  = '0;
      dst_w = '0;
      rs_w[REG_AW-1:0]  = id_rs;
      rt_w[REG_AW-1:0]  = id_rt;
      dst_w[REG_AW-1:0] = id_dst;
   end

   if (FWD_EN != 0) begin : g_fwd
      logic m_mem_a, m_mem_b, m_wb_a, m_wb_b, m_ex_rs, m_ex_rt;

      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_mem_a (.v(mem_q.v), .rw(mem_q.rw), .dst(mem_q.dst), .r(ex_q.rs), .match(m_mem_a));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_mem_b (.v(mem_q.v), .rw(mem_q.rw), .dst(mem_q.dst), .r(ex_q.rt), .match(m_mem_b));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_wb_a  (.v(wb_q.v),  .rw(wb_q.rw),  .dst(wb_q.dst),  .r(ex_q.rs), .match(m_wb_a));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_wb_b  (.v(wb_q.v),  .rw(wb_q.rw),  .dst(wb_q.dst),  .r(ex_q.rt), .match(m_wb_b));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_ex_rs (.v(ex_q.v),  .rw(ex_q.rw),  .dst(ex_q.dst),  .r(rs_w),    .match(m_ex_rs));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_ex_rt (.v(ex_q.v),  .rw(ex_q.rw),  .dst(ex_q.dst),  .r(rt_w),    .match(m_ex_rt));

      // MEM holds the younger producer, so it wins over WB
      assign fwd_a  = m_mem_a ? FWD_MEM : (m_wb_a ? FWD_WB : FWD_RF);
      assign fwd_b  = m_mem_b ? FWD_MEM : (m_wb_b ? FWD_WB : FWD_RF);
      assign haz_rs = m_ex_rs && ex_q.mr;
      assign haz_rt = m_ex_rt && ex_q.mr;
   end else begin : g_ilk
      logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt, m_wb_rs, m_wb_rt;

      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_ex_rs  (.v(ex_q.v),  .rw(ex_q.rw),  .dst(ex_q.dst),  .r(rs_w), .match(m_ex_rs));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_ex_rt  (.v(ex_q.v),  .rw(ex_q.rw),  .dst(ex_q.dst),  .r(rt_w), .match(m_ex_rt));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_mem_rs (.v(mem_q.v), .rw(mem_q.rw), .dst(mem_q.dst), .r(rs_w), .match(m_mem_rs));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_mem_rt (.v(mem_q.v), .rw(mem_q.rw), .dst(mem_q.dst), .r(rt_w), .match(m_mem_rt));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_wb_rs  (.v(wb_q.v),  .rw(wb_q.rw),  .dst(wb_q.dst),  .r(rs_w), .match(m_wb_rs));
      hazard_match #(.ZERO_HARD(ZERO_HARD)) u_wb_rt  (.v(wb_q.v),  .rw(wb_q.rw),  .dst(wb_q.dst),  .r(rt_w), .match(m_wb_rt));

      assign fwd_a  = FWD_RF;
      assign fwd_b  = FWD_RF;
      assign haz_rs = m_ex_rs || m_mem_rs || m_wb_rs;
      assign haz_rt = m_ex_rt || m_mem_rt || m_wb_rt;
   end

   assign raw_stall    = id_valid && (haz_rs || (id_uses_rt && haz_rt));
   assign stall        = raw_stall && !mem_branch_taken;
   assign bubble       = stall;
   assign flush_if_id  = mem_branch_taken;
   assign flush_id_ex  = mem_branch_taken;
   assign flush_ex_mem = mem_branch_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_count <= '0;
      end else begin
         wb_q      <= mem_q;
         mem_q.v   <= ex_q.v && !flush_ex_mem;
         mem_q.dst <= ex_q.dst;
         mem_q.rw  <= ex_q.rw;
         ex_q.v    <= id_valid && !bubble && !flush_id_ex;
         ex_q.dst  <= dst_w;
         ex_q.rw   <= id_reg_write;
         ex_q.mr   <= id_mem_read;
         ex_q.rs   <= rs_w;
         ex_q.rt   <= rt_w;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed bench for mips_hazard_unit: forwarding instance driven from a vector table,
// plus interlock-mode, saturation and asynchronous-reset sequences.
module tb_mips_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_uses_rt, id_reg_write, id_mem_read, mem_branch_taken;
   logic [4:0] id_rs, id_rt, id_dst;

   logic        d_stall, d_bubble, d_fii, d_fie, d_fem;
   logic [1:0]  d_fa, d_fb;
   logic [15:0] d_cnt;
   logic        i_stall, i_bubble, i_fii, i_fie, i_fem;
   logic [1:0]  i_fa, i_fb;
   logic [1:0]  i_cnt;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mips_hazard_unit #(.FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .mem_branch_taken(mem_branch_taken),
      .stall(d_stall), .bubble(d_bubble), .flush_if_id(d_fii), .flush_id_ex(d_fie),
      .flush_ex_mem(d_fem), .fwd_a(d_fa), .fwd_b(d_fb), .stall_count(d_cnt)
   );

   mips_hazard_unit #(.FWD_EN(0), .CNT_W(2)) il (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .mem_branch_taken(mem_branch_taken),
      .stall(i_stall), .bubble(i_bubble), .flush_if_id(i_fii), .flush_id_ex(i_fie),
      .flush_ex_mem(i_fem), .fwd_a(i_fa), .fwd_b(i_fb), .stall_count(i_cnt)
   );

   typedef struct {
      logic        v;
      logic [4:0]  rs, rt;
      logic        ut;
      logic [4:0]  dst;
      logic        rw, mr, br;
      logic        e_stall;
      logic [1:0]  e_fa, e_fb;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl[NV];

   task automatic tv(input int i, input logic v, input int rs, input int rt, input logic ut,
                     input int dst, input logic rw, input logic mr, input logic br,
                     input logic st, input logic [1:0] fa, input logic [1:0] fb, input int cnt);
      tbl[i].v = v;   tbl[i].rs = 5'(rs); tbl[i].rt = 5'(rt); tbl[i].ut = ut;
      tbl[i].dst = 5'(dst); tbl[i].rw = rw; tbl[i].mr = mr; tbl[i].br = br;
      tbl[i].e_stall = st; tbl[i].e_fa = fa; tbl[i].e_fb = fb; tbl[i].e_cnt = 16'(cnt);
   endtask

   task automatic set_id(input logic v, input int rs, input int rt, input logic ut,
                         input int dst, input logic rw, input logic mr, input logic br);
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ut;
      id_dst = 5'(dst); id_reg_write = rw; id_mem_read = mr; mem_branch_taken = br;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //    i  v rs rt ut dst rw mr br | stall fwd_a  fwd_b  cnt
      tv( 0, 1, 1, 2, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add $3
      tv( 1, 1, 3, 1, 1,  4, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add $4,$3,$1
      tv( 2, 1, 1, 2, 1,  3, 1, 0, 0,   0, 2'b10, 2'b00, 0); // consumer in EX: rs from MEM
      tv( 3, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0); // nop
      tv( 4, 1, 1, 3, 1,  5, 1, 0, 0,   0, 2'b00, 2'b00, 0); // sub $5,$1,$3
      tv( 5, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b01, 0); // rt from WB
      tv( 6, 1, 1, 2, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add $3
      tv( 7, 1, 1, 2, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add $3
      tv( 8, 1, 1, 2, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0); // add $3
      tv( 9, 1, 3, 3, 1, 10, 1, 0, 0,   0, 2'b00, 2'b00, 0); // or $10,$3,$3
      tv(10, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b10, 2'b10, 0); // $3 in MEM and WB: MEM wins
      tv(11, 1, 1, 2, 0,  2, 1, 1, 0,   0, 2'b00, 2'b00, 0); // lw $2
      tv(12, 1, 2, 2, 1,  6, 1, 0, 0,   1, 2'b00, 2'b00, 0); // add $6,$2,$2: load-use
      tv(13, 1, 2, 2, 1,  6, 1, 0, 0,   0, 2'b10, 2'b10, 1); // held once, no second stall
      tv(14, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b01, 2'b01, 1);
      tv(15, 1, 1, 2, 0,  2, 1, 1, 0,   0, 2'b00, 2'b00, 1); // lw $2
      tv(16, 1, 1, 2, 0,  2, 1, 1, 0,   0, 2'b00, 2'b00, 1); // lw $2 again (rt not read)
      tv(17, 1, 2, 0, 1, 11, 1, 0, 0,   1, 2'b00, 2'b10, 1); // add $11,$2,$0
      tv(18, 1, 2, 0, 1, 11, 1, 0, 0,   0, 2'b10, 2'b00, 2); // younger load in MEM wins
      tv(19, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b01, 2'b00, 2);
      tv(20, 1, 1, 2, 1,  0, 1, 0, 0,   0, 2'b00, 2'b00, 2); // add $0
      tv(21, 1, 1, 0, 0,  0, 1, 1, 0,   0, 2'b00, 2'b00, 2); // lw $0
      tv(22, 1, 0, 0, 1, 12, 1, 0, 0,   0, 2'b00, 2'b00, 2); // add $12,$0,$0: no stall
      tv(23, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 2); // no forward of $0
      tv(24, 1, 1, 4, 0,  4, 1, 1, 0,   0, 2'b00, 2'b00, 2); // lw $4
      tv(25, 0, 4, 4, 1,  0, 0, 0, 0,   0, 2'b00, 2'b00, 2); // invalid reader of $4
      tv(26, 1, 1, 5, 0,  5, 1, 1, 0,   0, 2'b10, 2'b10, 2); // lw $5
      tv(27, 1, 5, 5, 1, 13, 1, 0, 1,   0, 2'b00, 2'b00, 2); // load-use + branch taken
      tv(28, 1,13,13, 1, 14, 1, 0, 0,   0, 2'b00, 2'b00, 2); // flushed lw not forwarded
      tv(29, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 2); // flushed add $13 not forwarded

      rst = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("reset.stall",  32'(d_stall), 0);
      chk("reset.bubble", 32'(d_bubble), 0);
      chk("reset.fwd_a",  32'(d_fa), 0);
      chk("reset.fwd_b",  32'(d_fb), 0);
      chk("reset.flush",  {29'd0, d_fii, d_fie, d_fem}, 0);
      chk("reset.cnt",    32'(d_cnt), 0);
      chk("reset.il_stall", 32'(i_stall), 0);
      #4 rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         next_cycle();
         set_id(tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].ut,
                int'(tbl[i].dst), tbl[i].rw, tbl[i].mr, tbl[i].br);
         #3;
         chk($sformatf("v%0d.stall", i),  32'(d_stall),  32'(tbl[i].e_stall));
         chk($sformatf("v%0d.bubble", i), 32'(d_bubble), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d.fwd_a", i),  32'(d_fa),     32'(tbl[i].e_fa));
         chk($sformatf("v%0d.fwd_b", i),  32'(d_fb),     32'(tbl[i].e_fb));
         chk($sformatf("v%0d.flush", i),  {29'd0, d_fii, d_fie, d_fem}, {29'd0, {3{tbl[i].br}}});
         chk($sformatf("v%0d.cnt", i),    32'(d_cnt),    32'(tbl[i].e_cnt));
      end

      // Interlock instance: add $7 then or $8,$7,$0
      next_cycle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2 rst = 1'b0;

      next_cycle();
      set_id(1, 1, 2, 1, 7, 1, 0, 0);
      #3;
      chk("il0.stall", 32'(i_stall), 0);
      next_cycle();
      set_id(1, 7, 0, 1, 8, 1, 0, 0);
      #3;
      chk("il1.stall",  32'(i_stall), 1);
      chk("il1.bubble", 32'(i_bubble), 1);
      chk("il1.fwd_a",  32'(i_fa), 0);
      chk("il1.dut_stall", 32'(d_stall), 0);
      next_cycle();
      #3;
      chk("il2.stall", 32'(i_stall), 1);
      chk("il2.fwd_a", 32'(i_fa), 0);
      chk("il2.dut_fwd_a", 32'(d_fa), 32'(2'b10));
      next_cycle();
      #3;
      chk("il3.stall", 32'(i_stall), 1);
      chk("il3.fwd_b", 32'(i_fb), 0);
      chk("il3.cnt",   32'(i_cnt), 2);
      next_cycle();
      #3;
      chk("il4.stall", 32'(i_stall), 0);
      chk("il4.cnt",   32'(i_cnt), 3);

      // lw $2,0($8) behind or $8 (interlock stalls again, counter saturates), then load-use and async reset
      next_cycle();
      set_id(1, 8, 2, 0, 2, 1, 1, 0);
      #3;
      chk("r0.il_stall", 32'(i_stall), 1);
      next_cycle();
      set_id(1, 2, 2, 1, 6, 1, 0, 0);
      #3;
      chk("r1.stall",   32'(d_stall), 1);
      chk("r1.fwd_a",   32'(d_fa), 32'(2'b10));
      chk("r1.il_cnt_sat", 32'(i_cnt), 3);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid.stall",  32'(d_stall), 0);
      chk("rst_mid.bubble", 32'(d_bubble), 0);
      chk("rst_mid.fwd_a",  32'(d_fa), 0);
      chk("rst_mid.fwd_b",  32'(d_fb), 0);
      chk("rst_mid.cnt",    32'(d_cnt), 0);
      chk("rst_mid.il_stall", 32'(i_stall), 0);
      chk("rst_mid.il_cnt",   32'(i_cnt), 0);
      #1 rst = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Parametrised hazard controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow scoreboard of destination registers in flight in EX, MEM and WB.
- Produces EX-operand forwarding selects, load-use stall and bubble, and branch flush.
- Sits beside the pipeline buffers; drives their hold and clear inputs and the EX operand muxes.

Parameters:
- REG_AW, 5: register address width.
- FWD_EN, 1: 1 = forwarding with load-use interlock; 0 = interlock only, no forwarding.
- ZERO_HARD, 1: 1 = register 0 is never a hazard source.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_uses_rt  in  1  ID instruction reads rt as an operand.
- id_dst  in  REG_AW  ID destination, already RegDst-selected.
- id_reg_write  in  1  ID instruction writes the register file.
- id_mem_read  in  1  ID instruction is a load.
- mem_branch_taken  in  1  branch resolved taken in MEM (Branch AND zero flag).
- stall  out  1  hold PC and the IF/ID buffer.
- bubble  out  1  load a NOP into the ID/EX buffer.
- flush_if_id  out  1  clear the IF/ID buffer.
- flush_id_ex  out  1  clear the ID/EX buffer.
- flush_ex_mem  out  1  clear the EX/MEM buffer.
- fwd_a  out  2  EX operand A select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow entries:
  - EX entry: {v, dst, rw, mr, rs, rt}.
  - MEM entry: {v, dst, rw}.
  - WB entry: {v, dst, rw}.
- Reset (asynchronous): all v = 0, stall_count = 0. With every v = 0, all outputs evaluate to 0.
- Every rising clk:
  - WB <= MEM.
  - MEM <= EX, except MEM.v <= 0 when flush_ex_mem = 1.
  - EX <= ID fields with v = id_valid, except EX.v <= 0 when bubble or flush_id_ex = 1.
- "Producer P matches register r" means all of: P.v, P.rw, P.dst == r, and (ZERO_HARD = 0 or r != 0).
- Forwarding (combinational from EX.rs and EX.rt):
  - FWD_EN = 1: fwd_x = 10 if MEM matches; else 01 if WB matches; else 00. MEM has priority over WB.
  - FWD_EN = 0: fwd_x = 00 always.
- Hazard on register r (r = id_rs, or id_rt when id_uses_rt = 1):
  - FWD_EN = 1: EX matches r and EX.mr = 1 (load-use).
  - FWD_EN = 0: any of EX, MEM or WB matches r.
- Stall:
  - raw_stall = id_valid AND a hazard on id_rs or id_rt.
  - stall = bubble = raw_stall AND NOT mem_branch_taken.
- Latency:
  - A load-use costs exactly 1 stall cycle.
  - Interlock mode costs up to 3 stall cycles, while the producer moves EX→MEM→WB.
  - The consumer enters EX the cycle after the producer leaves WB.
- Branch flush:
  - mem_branch_taken = 1 asserts flush_if_id, flush_id_ex and flush_ex_mem in the same cycle.
  - Branch overrides stall.
  - The branch instruction itself proceeds to WB (MEM is not cleared).
- stall_count: +1 on each cycle with stall = 1; holds at 2^CNT_W − 1.
- Boundary conditions:
  - rs == rt, both hazarded: a single stall.
  - Producer dst = 0 with ZERO_HARD = 1: no forwarding, no stall.
  - Back-to-back loads into the same register: MEM priority supplies the youngest value.
  - rst asserted mid-stall: outputs drop to 0 immediately (asynchronous).
  - An instruction with id_valid = 0 is never a hazard consumer.

Decomposition:
- Package mips_hazard_pkg holds:
  - fwd select constants FWD_RF = 2'b00, FWD_MEM = 2'b10, FWD_WB = 2'b01;
  - the shadow-entry struct type;
  - the REG_AW default.
- One sub-module, hazard_match:
  - combinational compare of one producer entry against one register;
  - instanced 6× in forward mode, 6× in interlock mode.
- All state stays in the top.

Test Plan:
- Forward from MEM: add $3 then add $4,$3,$1 (FWD_EN = 1) -> consumer-in-EX cycle has fwd_a = 10, stall = 0.
- Forward from WB: add $3; nop; sub $5,$1,$3 -> fwd_b = 01, no stall. Same $3 written in both MEM and WB -> 10.
- Load-use: lw $2 then add $6,$2,$2 -> stall = bubble = 1 for exactly 1 cycle, then fwd_a = fwd_b = 10, stall_count = 1.
- Interlock: FWD_EN = 0, add $7 then or $8,$7,$0 -> stall held 3 cycles, fwd always 00, stall_count = 3.
- Branch during stall: raw_stall = 1 and mem_branch_taken = 1 in the same cycle -> stall = 0, all three flushes = 1. Next cycle EX.v = MEM.v = 0, and no forwards from the flushed instructions.
- Zero register and reset: producer dst = 0 with a consumer reading $0 -> fwd 00, no stall. rst pulsed mid-stall -> stall, fwd and stall_count = 0 asynchronously.
